mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer in front of the memory-cell read/write controller. Two requesters (ports 0 and 1) each issue single read or write transactions. The block grants the shared memory controller round-robin and drives its `sel`/`op` command lines. It also returns read data and a completion pulse to the winning port, and aborts any transaction the controller fails to acknowledge within a bounded number of cycles.

## Interface
- `AW`, 4: address width.
- `DW`, 8: data width.
- `TIMEOUT`, 15: maximum BUSY cycles before abort; legal range 1..255.

- `clk`  in  1  sole clock; every register updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset, sampled on the `clk` rising edge.
- `req0`, `req1`  in  1  transaction request per port; held until that port's `done`.
- `op0`, `op1`  in  1  operation: 1 = write, 0 = read; stable while `req` is high.
- `addr0`, `addr1`  in  AW  address; stable while `req` is high.
- `wdata0`, `wdata1`  in  DW  write data; stable while `req` is high.
- `gnt0`, `gnt1`  out  1  high for the whole time the port owns the controller (BUSY and DONE).
- `done0`, `done1`  out  1  one-cycle completion pulse.
- `rdata`  out  DW  read result; valid in the `done` cycle of a successful read.
- `err`  out  1  high together with `done` when the transaction timed out.
- `mem_sel`  out  1  command strobe to the controller.
- `mem_op`  out  1  operation to the controller (1 = write).
- `mem_addr`  out  AW  registered address.
- `mem_wdata`  out  DW  registered write data.
- `mem_rdata`  in  DW  controller read data.
- `mem_valid`  in  1  controller acknowledge: read data valid, or write committed.

## Operation
- **Outputs:** all outputs are registered.
- **Reset values:** every output is 0; state is IDLE; the round-robin pointer is 0; the timeout counter is 0.
- **States:** IDLE, BUSY, DONE.
- **IDLE:**
  - No request: stay in IDLE.
  - Exactly one `reqN`: grant port N.
  - Both requests: grant the port selected by the pointer.
  - On grant: latch `opN`/`addrN`/`wdataN` into `mem_op`/`mem_addr`/`mem_wdata`, set `mem_sel` = 1 and `gntN` = 1, clear the counter, go to BUSY.
- **BUSY:**
  - `mem_sel` stays 1 and the command lines stay frozen; the counter increments every cycle.
  - `mem_valid` = 1: capture `mem_rdata` into `rdata` for a read; leave `rdata` unchanged for a write. Set `mem_sel` = 0 and `doneN` = 1, go to DONE.
  - Counter reaches TIMEOUT with no `mem_valid`: set `err` = 1 and `doneN` = 1, set `mem_sel` = 0, leave `rdata` unchanged, go to DONE.
  - `mem_valid` in the same cycle the counter reaches TIMEOUT: treat as success; `err` stays 0.
- **DONE:**
  - Lasts exactly one cycle, during which `doneN` and `err` are visible and `mem_sel` = 0. This cycle is also the controller's turnaround, so it returns to idle.
  - Exit: clear `doneN`, `err` and `gntN`; set the pointer to the other port; go to IDLE.
- **Ignored events:**
  - `mem_valid` in IDLE or DONE.
  - `reqN` dropping during BUSY; the transaction still completes.
  - The non-granted `req` during BUSY or DONE.
- **Width rules:** the counter is `$clog2(TIMEOUT+1)` bits and saturates at the compare; nothing wraps.
- **Reset mid-transaction:** takes effect at the next edge. `mem_sel` drops, no `done` is issued, and the pointer returns to 0.

## Timing
- **Grant latency:** `req` sampled high at edge k in IDLE gives `mem_sel` = 1 and `gnt` = 1 from edge k.
- **Completion:** `mem_valid` sampled at edge m gives `done`/`rdata` from edge m, valid for one cycle; IDLE resumes at edge m+1.
- **Minimum transaction:** 3 cycles from grant to the next possible grant (BUSY 1, DONE 1, IDLE 1).
- **Requester rule:** drop `req` within the cycle following `done`. A `req` still high at the first IDLE edge is a new transaction.
- **Alternation:** with both ports continuously requesting, grants alternate 0, 1, 0, 1 …; no port waits more than one transaction.

## Structure
- **Shared package `mem_pkg`:**
  - state encoding: IDLE, BUSY, DONE;
  - `OP_READ` = 0, `OP_WRITE` = 1;
  - default `AW`/`DW`.
  - The existing memory-controller FSM also uses the op encoding.
- **Sub-module `mem_rr_pick`:** the combinational 2-way round-robin picker. Inputs are `req0`, `req1` and the pointer; outputs are the one-hot pick and `any`. It is instantiated once.
- **Top level:** the state register, counter, pointer, and command/response registers.

## Test plan
- **Reset:** reset held 2 cycles with `req0` = 1 → all outputs 0; first grant occurs the edge after reset releases.
- **Single write:** `req0`, op = 1, addr = 4'h3, wdata = 8'hA5; `mem_valid` 2 cycles after `mem_sel` → `mem_op` = 1, `mem_addr` = 3, `mem_wdata` = A5; `done0` for one cycle, `err` = 0, `rdata` unchanged.
- **Single read:** `req1`, op = 0, addr = 4'hC; `mem_rdata` = 8'h5A with `mem_valid` → `rdata` = 5A in the `done1` cycle; `gnt0` stays 0.
- **Contention:** `req0` and `req1` both high from reset, each acked after 1 cycle → grant order 0, 1, 0, 1; each `done` is followed by a 1-cycle `mem_sel` = 0 gap.
- **Timeout:** TIMEOUT = 4, no `mem_valid` → `done0` = 1 and `err` = 1 after 4 BUSY cycles, `mem_sel` falls; next grant goes to port 1 if it is requesting.
- **Reset during BUSY:** reset asserted → `mem_sel`, `gnt` and `done` are 0 at the next edge; a late `mem_valid` afterwards produces no `done`.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared state/op encodings and default widths for the memory arbiter
package mem_pkg;
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   localparam logic OP_READ = 1'b0;
   localparam logic OP_WRITE = 1'b1;
   localparam int AW = 4;
   localparam int DW = 8;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester ports plus memory-controller command/response lines
interface mem_arbiter_if #(parameter int AW = mem_pkg::AW, parameter int DW = mem_pkg::DW);
   logic req0, req1, op0, op1;
   logic [AW-1:0] addr0, addr1, mem_addr;
   logic [DW-1:0] wdata0, wdata1, mem_wdata, mem_rdata, rdata;
   logic gnt0, gnt1, done0, done1, err, mem_sel, mem_op, mem_valid;
   modport master (
      input req0, req1, op0, op1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_valid,
      output gnt0, gnt1, done0, done1, rdata, err, mem_sel, mem_op, mem_addr, mem_wdata
   );
   modport slave (
      output req0, req1, op0, op1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_valid,
      input gnt0, gnt1, done0, done1, rdata, err, mem_sel, mem_op, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_rr_pick.sv
// mem_rr_pick: two-way round-robin picker; the pointer only matters on contention
module mem_rr_pick (
   input logic req0,
   input logic req1,
   input logic ptr,
   output logic [1:0] pick,
   output logic any
);
   // one-hot pick: a lone request always wins, ptr breaks ties
   always_comb begin
      pick = {req1 && (!req0 || ptr), req0 && (!req1 || !ptr)};
      any = req0 || req1;
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin two-port sequencer with timeout in front of the memory controller
module mem_arbiter import mem_pkg::*; #(parameter int TIMEOUT = 15) (
   input logic clk,
   input logic reset,
   mem_arbiter_if.master bus
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TLIM = CW'(TIMEOUT);
   state_t state, state_n;
   logic ptr, own, any, grant, ok, tmo, fin;
   logic [1:0] pick;
   logic [CW-1:0] cnt;

   mem_rr_pick u_pick (.req0(bus.req0), .req1(bus.req1), .ptr(ptr), .pick(pick), .any(any));

   // grant/finish events and next state; a valid ack wins over a same-cycle timeout
   always_comb begin
      grant = state == IDLE && any;
      ok = state == BUSY && bus.mem_valid;
      tmo = state == BUSY && !bus.mem_valid && cnt + 1'b1 == TLIM;
      fin = ok || tmo;
      state_n = grant ? BUSY : fin ? DONE : state == DONE ? IDLE : state;
   end

   // state, counter, owner, pointer and every registered output
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         ptr <= 1'b0;
         own <= 1'b0;
         cnt <= '0;
         bus.gnt0 <= 1'b0;
         bus.gnt1 <= 1'b0;
         bus.done0 <= 1'b0;
         bus.done1 <= 1'b0;
         bus.err <= 1'b0;
         bus.rdata <= '0;
         bus.mem_sel <= 1'b0;
         bus.mem_op <= 1'b0;
         bus.mem_addr <= '0;
         bus.mem_wdata <= '0;
      end else begin
         state <= state_n;
         cnt <= grant ? '0 : (state == BUSY && cnt != TLIM) ? cnt + 1'b1 : cnt;
         if (grant) begin
            own <= pick[1];
            bus.mem_op <= pick[1] ? bus.op1 : bus.op0;
            bus.mem_addr <= pick[1] ? bus.addr1 : bus.addr0;
            bus.mem_wdata <= pick[1] ? bus.wdata1 : bus.wdata0;
         end
         if (state == DONE) ptr <= !own;
         if (ok && bus.mem_op == OP_READ) bus.rdata <= bus.mem_rdata;
         bus.mem_sel <= grant || (state == BUSY && !fin);
         bus.gnt0 <= grant ? pick[0] : state != DONE && bus.gnt0;
         bus.gnt1 <= grant ? pick[1] : state != DONE && bus.gnt1;
         bus.done0 <= fin && !own;
         bus.done1 <= fin && own;
         bus.err <= tmo;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for the two-port memory arbiter
module tb_mem_arbiter;
   import mem_pkg::*;
   typedef struct {
      logic port;
      logic op;
      logic [3:0] addr;
      logic [7:0] wdata;
      logic [7:0] rdata;
      logic err;
      logic [7:0] lat;
   } exp_t;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic late_valid = 1'b0, resp_v = 1'b0, sel_q = 1'b0, gap = 1'b0;
   logic [7:0] rd_model = 8'h00;
   int dly[2] = '{0, 0};
   int wait_cnt = 0, cyc = 0, t0 = 0, n = 0;
   int vectors = 0, miscompares = 0;
   exp_t sb[$];
   exp_t e;

   mem_arbiter_if #(.AW(4), .DW(8)) bus ();
   mem_arbiter #(.TIMEOUT(4)) dut (.clk(clk), .reset(reset), .bus(bus));

   function automatic logic [7:0] mem_word(input logic [3:0] a);
      return {a, ~a} ^ 8'h99;
   endfunction

   assign bus.mem_valid = resp_v | late_valid;
   assign bus.mem_rdata = mem_word(bus.mem_addr);

   always #5 clk = ~clk;

   // edge counter used to measure grant-to-done latency
   always @(posedge clk) cyc <= cyc + 1;

   // controller model: ack the owning port after its configured number of cycles
   always @(negedge clk) begin
      if (bus.mem_sel && !resp_v && (bus.gnt0 || bus.gnt1)) begin
         if (wait_cnt == dly[bus.gnt1]) resp_v = 1'b1;
         else wait_cnt++;
      end else begin
         resp_v = 1'b0;
         wait_cnt = 0;
      end
   end

   task test_reset;
      {bus.req0, bus.op0, bus.addr0, bus.wdata0} = {1'b1, OP_WRITE, 4'h9, 8'h3C};
      {bus.req1, bus.op1, bus.addr1, bus.wdata1} = '0;
      dly[0] = 0;
      dly[1] = 0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.mem_sel, bus.mem_op, bus.mem_addr, bus.mem_wdata, bus.rdata} !== '0) begin
         miscompares++;
         $display("FAIL reset_outputs: gnt0,gnt1,done0,done1,err,sel=%b%b%b%b%b%b op=%b addr=%h wdata=%h rdata=%h want all 0",
                  bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.mem_sel, bus.mem_op, bus.mem_addr, bus.mem_wdata, bus.rdata);
      end
      reset = 1'b0;
      rd_model = 8'h00;
      @(negedge clk);
      vectors++;
      if ({bus.mem_sel, bus.gnt0, bus.gnt1, bus.mem_op, bus.mem_addr, bus.mem_wdata} !== {3'b110, OP_WRITE, 4'h9, 8'h3C}) begin
         miscompares++;
         $display("FAIL first_grant: sel,gnt0,gnt1=%b%b%b op=%b addr=%h wdata=%h want 110 1 9 3c",
                  bus.mem_sel, bus.gnt0, bus.gnt1, bus.mem_op, bus.mem_addr, bus.mem_wdata);
      end
      t0 = cyc;
      sel_q = bus.mem_sel;
      sb.push_back('{1'b0, OP_WRITE, 4'h9, 8'h3C, rd_model, 1'b0, 8'd1});
      gap = 1'b0;
      for (int c = 0; c < 200 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (gap) begin
            vectors++;
            if ({bus.mem_sel, bus.gnt1, bus.gnt0} !== 3'b000) begin
               miscompares++;
               $display("FAIL gap: sel,gnt1,gnt0=%b want 000", {bus.mem_sel, bus.gnt1, bus.gnt0});
            end
         end
         gap = bus.done0 | bus.done1;
         if (gap) begin
            e = sb.pop_front();
            vectors++;
            if ({bus.done1, bus.done0, bus.err, bus.mem_sel, bus.rdata, 8'(cyc - t0)} !== {e.port, !e.port, e.err, 1'b0, e.rdata, e.lat}) begin
               miscompares++;
               $display("FAIL done: done1,done0,err,sel=%b%b%b%b rdata=%h lat=%0d want %b%b%b0 rdata=%h lat=%0d",
                        bus.done1, bus.done0, bus.err, bus.mem_sel, bus.rdata, cyc - t0, e.port, !e.port, e.err, e.rdata, e.lat);
            end
            n = 0;
            foreach (sb[i]) n += int'(sb[i].port == e.port);
            if (n == 0) begin
               if (e.port) bus.req1 = 1'b0;
               else bus.req0 = 1'b0;
            end
         end
         sel_q = bus.mem_sel;
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL reset_stall: %0d transactions outstanding want 0", sb.size());
         sb.delete();
      end
   endtask

   task test_single;
      dly[0] = 2;
      dly[1] = 1;
      {bus.req1, bus.op1, bus.addr1, bus.wdata1} = {1'b1, OP_READ, 4'hC, 8'h00};
      {bus.req0, bus.op0, bus.addr0, bus.wdata0} = {1'b1, OP_WRITE, 4'h3, 8'hA5};
      rd_model = mem_word(4'hC);
      sb.push_back('{1'b1, OP_READ, 4'hC, 8'h00, rd_model, 1'b0, 8'd2});
      sb.push_back('{1'b0, OP_WRITE, 4'h3, 8'hA5, rd_model, 1'b0, 8'd3});
      sel_q = bus.mem_sel;
      for (int c = 0; c < 200 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (gap) begin
            vectors++;
            if ({bus.mem_sel, bus.gnt1, bus.gnt0} !== 3'b000) begin
               miscompares++;
               $display("FAIL gap: sel,gnt1,gnt0=%b want 000", {bus.mem_sel, bus.gnt1, bus.gnt0});
            end
         end
         if (bus.mem_sel && !sel_q) begin
            t0 = cyc;
            vectors++;
            if ({bus.gnt1, bus.gnt0, bus.mem_op, bus.mem_addr, bus.mem_wdata} !== {sb[0].port, !sb[0].port, sb[0].op, sb[0].addr, sb[0].wdata}) begin
               miscompares++;
               $display("FAIL cmd: gnt1,gnt0,op=%b%b%b addr=%h wdata=%h want %b%b%b addr=%h wdata=%h",
                        bus.gnt1, bus.gnt0, bus.mem_op, bus.mem_addr, bus.mem_wdata, sb[0].port, !sb[0].port, sb[0].op, sb[0].addr, sb[0].wdata);
            end
         end
         gap = bus.done0 | bus.done1;
         if (gap) begin
            e = sb.pop_front();
            vectors++;
            if ({bus.done1, bus.done0, bus.err, bus.mem_sel, bus.rdata, 8'(cyc - t0)} !== {e.port, !e.port, e.err, 1'b0, e.rdata, e.lat}) begin
               miscompares++;
               $display("FAIL done: done1,done0,err,sel=%b%b%b%b rdata=%h lat=%0d want %b%b%b0 rdata=%h lat=%0d",
                        bus.done1, bus.done0, bus.err, bus.mem_sel, bus.rdata, cyc - t0, e.port, !e.port, e.err, e.rdata, e.lat);
            end
            n = 0;
            foreach (sb[i]) n += int'(sb[i].port == e.port);
            if (n == 0) begin
               if (e.port) bus.req1 = 1'b0;
               else bus.req0 = 1'b0;
            end
         end
         sel_q = bus.mem_sel;
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL single_stall: %0d transactions outstanding want 0", sb.size());
         sb.delete();
      end
   endtask

   task test_reset_busy;
      dly[0] = 255;
      dly[1] = 255;
      {bus.req0, bus.op0, bus.addr0, bus.wdata0} = {1'b1, OP_WRITE, 4'h6, 8'h11};
      for (int c = 0; c < 10 && !bus.mem_sel; c++) @(negedge clk);
      vectors++;
      if ({bus.mem_sel, bus.gnt0} !== 2'b11) begin
         miscompares++;
         $display("FAIL busy_grant: sel,gnt0=%b%b want 11", bus.mem_sel, bus.gnt0);
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      vectors++;
      if ({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.mem_sel, bus.mem_op, bus.mem_addr, bus.mem_wdata, bus.rdata} !== '0) begin
         miscompares++;
         $display("FAIL busy_reset: gnt0,gnt1,done0,done1,err,sel=%b%b%b%b%b%b op=%b addr=%h wdata=%h rdata=%h want all 0",
                  bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err, bus.mem_sel, bus.mem_op, bus.mem_addr, bus.mem_wdata, bus.rdata);
      end
      bus.req0 = 1'b0;
      reset = 1'b0;
      rd_model = 8'h00;
      late_valid = 1'b1;
      repeat (2) begin
         @(negedge clk);
         vectors++;
         if ({bus.done0, bus.done1, bus.err, bus.mem_sel} !== 4'b0000) begin
            miscompares++;
            $display("FAIL late_valid: done0,done1,err,sel=%b%b%b%b want 0000", bus.done0, bus.done1, bus.err, bus.mem_sel);
         end
      end
      late_valid = 1'b0;
      dly[0] = 0;
      dly[1] = 0;
      {bus.req0, bus.op0, bus.addr0, bus.wdata0} = {1'b1, OP_READ, 4'h2, 8'h00};
      {bus.req1, bus.op1, bus.addr1, bus.wdata1} = {1'b1, OP_WRITE, 4'hD, 8'h77};
      rd_model = mem_word(4'h2);
      sb.push_back('{1'b0, OP_READ, 4'h2, 8'h00, rd_model, 1'b0, 8'd1});
      sb.push_back('{1'b1, OP_WRITE, 4'hD, 8'h77, rd_model, 1'b0, 8'd1});
      sel_q = bus.mem_sel;
      gap = 1'b0;
      for (int c = 0; c < 200 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (gap) begin
            vectors++;
            if ({bus.mem_sel, bus.gnt1, bus.gnt0} !== 3'b000) begin
               miscompares++;
               $display("FAIL gap: sel,gnt1,gnt0=%b want 000", {bus.mem_sel, bus.gnt1, bus.gnt0});
            end
         end
         if (bus.mem_sel && !sel_q) begin
            t0 = cyc;
            vectors++;
            if ({bus.gnt1, bus.gnt0, bus.mem_op, bus.mem_addr, bus.mem_wdata} !== {sb[0].port, !sb[0].port, sb[0].op, sb[0].addr, sb[0].wdata}) begin
               miscompares++;
               $display("FAIL cmd: gnt1,gnt0,op=%b%b%b addr=%h wdata=%h want %b%b%b addr=%h wdata=%h",
                        bus.gnt1, bus.gnt0, bus.mem_op, bus.mem_addr, bus.mem_wdata, sb[0].port, !sb[0].port, sb[0].op, sb[0].addr, sb[0].wdata);
            end
         end
         gap = bus.done0 | bus.done1;
         if (gap) begin
            e = sb.pop_front();
            vectors++;
            if ({bus.done1, bus.done0, bus.err, bus.mem_sel, bus.rdata, 8'(cyc - t0)} !== {e.port, !e.port, e.err, 1'b0, e.rdata, e.lat}) begin
               miscompares++;
               $display("FAIL done: done1,done0,err,sel=%b%b%b%b rdata=%h lat=%0d want %b%b%b0 rdata=%h lat=%0d",
                        bus.done1, bus.done0, bus.err, bus.mem_sel, bus.rdata, cyc - t0, e.port, !e.port, e.err, e.rdata, e.lat);
            end
            n = 0;
            foreach (sb[i]) n += int'(sb[i].port == e.port);
            if (n == 0) begin
               if (e.port) bus.req1 = 1'b0;
               else bus.req0 = 1'b0;
            end
         end
         sel_q = bus.mem_sel;
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL reset_busy_stall: %0d transactions outstanding want 0", sb.size());
         sb.delete();
      end
   endtask

   task test_contention;
      dly[0] = 0;
      dly[1] = 0;
      {bus.req0, bus.op0, bus.addr0, bus.wdata0} = {1'b1, OP_READ, 4'h1, 8'h00};
      {bus.req1, bus.op1, bus.addr1, bus.wdata1} = {1'b1, OP_WRITE, 4'h2, 8'h42};
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      rd_model = mem_word(4'h1);
      repeat (2) begin
         sb.push_back('{1'b0, OP_READ, 4'h1, 8'h00, rd_model, 1'b0, 8'd1});
         sb.push_back('{1'b1, OP_WRITE, 4'h2, 8'h42, rd_model, 1'b0, 8'd1});
      end
      sel_q = bus.mem_sel;
      gap = 1'b0;
      for (int c = 0; c < 200 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (gap) begin
            vectors++;
            if ({bus.mem_sel, bus.gnt1, bus.gnt0} !== 3'b000) begin
               miscompares++;
               $display("FAIL gap: sel,gnt1,gnt0=%b want 000", {bus.mem_sel, bus.gnt1, bus.gnt0});
            end
         end
         if (bus.mem_sel && !sel_q) begin
            t0 = cyc;
            vectors++;
            if ({bus.gnt1, bus.gnt0, bus.mem_op, bus.mem_addr, bus.mem_wdata} !== {sb[0].port, !sb[0].port, sb[0].op, sb[0].addr, sb[0].wdata}) begin
               miscompares++;
               $display("FAIL cmd: gnt1,gnt0,op=%b%b%b addr=%h wdata=%h want %b%b%b addr=%h wdata=%h",
                        bus.gnt1, bus.gnt0, bus.mem_op, bus.mem_addr, bus.mem_wdata, sb[0].port, !sb[0].port, sb[0].op, sb[0].addr, sb[0].wdata);
            end
         end
         gap = bus.done0 | bus.done1;
         if (gap) begin
            e = sb.pop_front();
            vectors++;
            if ({bus.done1, bus.done0, bus.err, bus.mem_sel, bus.rdata, 8'(cyc - t0)} !== {e.port, !e.port, e.err, 1'b0, e.rdata, e.lat}) begin
               miscompares++;
               $display("FAIL done: done1,done0,err,sel=%b%b%b%b rdata=%h lat=%0d want %b%b%b0 rdata=%h lat=%0d",
                        bus.done1, bus.done0, bus.err, bus.mem_sel, bus.rdata, cyc - t0, e.port, !e.port, e.err, e.rdata, e.lat);
            end
            n = 0;
            foreach (sb[i]) n += int'(sb[i].port == e.port);
            if (n == 0) begin
               if (e.port) bus.req1 = 1'b0;
               else bus.req0 = 1'b0;
            end
         end
         sel_q = bus.mem_sel;
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL contention_stall: %0d transactions outstanding want 0", sb.size());
         sb.delete();
      end
   endtask

   task test_timeout;
      dly[0] = 255;
      dly[1] = 3;
      {bus.req0, bus.op0, bus.addr0, bus.wdata0} = {1'b1, OP_READ, 4'h7, 8'h00};
      {bus.req1, bus.op1, bus.addr1, bus.wdata1} = {1'b1, OP_READ, 4'h8, 8'h00};
      sb.push_back('{1'b0, OP_READ, 4'h7, 8'h00, rd_model, 1'b1, 8'd4});
      rd_model = mem_word(4'h8);
      sb.push_back('{1'b1, OP_READ, 4'h8, 8'h00, rd_model, 1'b0, 8'd4});
      sel_q = bus.mem_sel;
      for (int c = 0; c < 200 && sb.size() > 0; c++) begin
         @(negedge clk);
         if (gap) begin
            vectors++;
            if ({bus.mem_sel, bus.gnt1, bus.gnt0} !== 3'b000) begin
               miscompares++;
               $display("FAIL gap: sel,gnt1,gnt0=%b want 000", {bus.mem_sel, bus.gnt1, bus.gnt0});
            end
         end
         if (bus.mem_sel && !sel_q) begin
            t0 = cyc;
            vectors++;
            if ({bus.gnt1, bus.gnt0, bus.mem_op, bus.mem_addr, bus.mem_wdata} !== {sb[0].port, !sb[0].port, sb[0].op, sb[0].addr, sb[0].wdata}) begin
               miscompares++;
               $display("FAIL cmd: gnt1,gnt0,op=%b%b%b addr=%h wdata=%h want %b%b%b addr=%h wdata=%h",
                        bus.gnt1, bus.gnt0, bus.mem_op, bus.mem_addr, bus.mem_wdata, sb[0].port, !sb[0].port, sb[0].op, sb[0].addr, sb[0].wdata);
            end
         end
         gap = bus.done0 | bus.done1;
         if (gap) begin
            e = sb.pop_front();
            vectors++;
            if ({bus.done1, bus.done0, bus.err, bus.mem_sel, bus.rdata, 8'(cyc - t0)} !== {e.port, !e.port, e.err, 1'b0, e.rdata, e.lat}) begin
               miscompares++;
               $display("FAIL done: done1,done0,err,sel=%b%b%b%b rdata=%h lat=%0d want %b%b%b0 rdata=%h lat=%0d",
                        bus.done1, bus.done0, bus.err, bus.mem_sel, bus.rdata, cyc - t0, e.port, !e.port, e.err, e.rdata, e.lat);
            end
            n = 0;
            foreach (sb[i]) n += int'(sb[i].port == e.port);
            if (n == 0) begin
               if (e.port) bus.req1 = 1'b0;
               else bus.req0 = 1'b0;
            end
         end
         sel_q = bus.mem_sel;
      end
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL timeout_stall: %0d transactions outstanding want 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_reset_busy();
      test_contention();
      test_timeout();
      repeat (2) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
